branch_resolver: RTL

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/branch_resolver.sv
// branch_resolver: resolves one conditional branch at a time. It captures a
// request, evaluates the condition with a dedicated subtractor, presents a
// redirect target to fetch for taken branches, then pulses flush for two cycles.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. in_valid/in_ready carries requests, and in_ready is high only
// in IDLE. redirect_valid/redirect_ack carries the redirect: redirect_valid is
// held with a stable redirect_pc until the edge where redirect_ack is seen.
module branch_resolver #(
  // Ceiling at which both event counters stop incrementing.
  parameter logic [15:0] CNT_MAX = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic [31:0] pc_in,
  input  logic [31:0] imm,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ack,
  output logic        flush,
  output logic [15:0] branch_count,
  output logic [15:0] taken_count,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RESOLVE  = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;
  localparam logic [1:0] S_FLUSH    = 2'd3;

  localparam logic [1:0] OP_BNE = 2'b00;
  localparam logic [1:0] OP_BLT = 2'b01;
  localparam logic [1:0] OP_BGE = 2'b10;
  localparam logic [1:0] OP_BEQ = 2'b11;

  logic [1:0]  state_q, state_d;
  logic        flush_cnt_q, flush_cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [15:0] branch_count_q, branch_count_d;
  logic [15:0] taken_count_q, taken_count_d;

  logic [31:0] diff;
  logic        lt;
  logic        ne;
  logic        taken;

  // Condition evaluation from the captured operands: A - B as A + ~B + 1.
  // When the signs differ the subtraction may overflow, so A's sign decides.
  always_comb begin
    diff = a_q + ~b_q + 32'd1;
    lt   = (a_q[31] != b_q[31]) ? a_q[31] : diff[31];
    ne   = |diff;
    unique case (op_q)
      OP_BNE:  taken = ne;
      OP_BLT:  taken = lt;
      OP_BGE:  taken = ~lt;
      OP_BEQ:  taken = ~ne;
      default: taken = 1'b0;
    endcase
  end

  // Next-state, capture, target and counter update logic.
  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    pc_d           = pc_q;
    imm_d          = imm_q;
    redirect_pc_d  = redirect_pc_q;
    branch_count_d = branch_count_q;
    taken_count_d  = taken_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          a_d     = data_operandA;
          b_d     = data_operandB;
          pc_d    = pc_in;
          imm_d   = imm;
          state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        if (branch_count_q != CNT_MAX) branch_count_d = branch_count_q + 16'd1;
        if (taken) begin
          if (taken_count_q != CNT_MAX) taken_count_d = taken_count_q + 16'd1;
          // Target is latched here so it is stable for the whole REDIRECT stay.
          redirect_pc_d = pc_q + 32'd1 + imm_q;
          state_d       = S_REDIRECT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REDIRECT: begin
        if (redirect_ack) begin
          flush_cnt_d = 1'b0;
          state_d     = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q) begin
          flush_cnt_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          flush_cnt_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset returns to IDLE with all captured data cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      flush_cnt_q    <= 1'b0;
      op_q           <= 2'b00;
      a_q            <= 32'd0;
      b_q            <= 32'd0;
      pc_q           <= 32'd0;
      imm_q          <= 32'd0;
      redirect_pc_q  <= 32'd0;
      branch_count_q <= 16'd0;
      taken_count_q  <= 16'd0;
    end else begin
      state_q        <= state_d;
      flush_cnt_q    <= flush_cnt_d;
      op_q           <= op_d;
      a_q            <= a_d;
      b_q            <= b_d;
      pc_q           <= pc_d;
      imm_q          <= imm_d;
      redirect_pc_q  <= redirect_pc_d;
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
    end
  end

  // Outputs decode directly from state so reset affects them without an edge.
  always_comb begin
    in_ready       = (state_q == S_IDLE);
    redirect_valid = (state_q == S_REDIRECT);
    flush          = (state_q == S_FLUSH);
    redirect_pc    = redirect_pc_q;
    branch_count   = branch_count_q;
    taken_count    = taken_count_q;
    state_dbg      = state_q;
  end

endmodule
